// File: rtl/alub_uop_seq_if.sv
// Instruction-in / micro-op-out bundle for the ALU B-input micro-op sequencer.
// master = fetch/test side, slave = sequencer.
interface alub_uop_seq_if;
  logic        INSTR_VALID;
  logic [15:0] INSTR;
  logic        INSTR_READY;
  logic        STALL;
  logic        UOP_VALID;
  logic [2:0]  ALUB_SRCX;
  logic [3:0]  ARGA_X;
  logic [3:0]  ARGB_X;
  logic [1:0]  LDSINCF;
  logic        UOP_LAST;

  modport master (
    output INSTR_VALID, INSTR, STALL,
    input  INSTR_READY, UOP_VALID, ALUB_SRCX, ARGA_X, ARGB_X, LDSINCF, UOP_LAST
  );

  modport slave (
    input  INSTR_VALID, INSTR, STALL,
    output INSTR_READY, UOP_VALID, ALUB_SRCX, ARGA_X, ARGB_X, LDSINCF, UOP_LAST
  );
endinterface

// File: rtl/alub_uop_seq.sv
// Decodes 16-bit instruction words into registered ALU B-source micro-ops;
// a LIT16 prefix expands the following word into a U8 / U8H micro-op pair.
module alub_uop_seq (
  input  logic         CLK,
  input  logic         RESETN,
  input  logic         FLUSH,
  alub_uop_seq_if.slave bus
);
  localparam logic [2:0] SRC_U8H  = 3'd1;
  localparam logic [2:0] SRC_U8   = 3'd2;
  localparam logic [2:0] MODE_LIT = 3'd7;

  typedef enum logic [1:0] {IDLE, WAIT_LIT, LIT_HI} state_t;

  state_t      state, state_nxt;
  logic        uop_valid, uop_valid_nxt;
  logic        uop_last, uop_last_nxt;
  logic [2:0]  srcx, srcx_nxt;
  logic [3:0]  arga, arga_nxt;
  logic [3:0]  argb, argb_nxt;
  logic [1:0]  ldsinc, ldsinc_nxt;
  logic [7:0]  lit_hi, lit_hi_nxt;

  logic        slot_free, instr_ready, accept, consume;
  logic [2:0]  mode;

  // A stall only matters while a micro-op is actually being presented.
  assign slot_free   = !uop_valid || !bus.STALL;
  assign instr_ready = !FLUSH && (state != LIT_HI) && slot_free;
  assign accept      = bus.INSTR_VALID && instr_ready;
  assign consume     = uop_valid && !bus.STALL;
  assign mode        = bus.INSTR[15:13];

  // State register
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (FLUSH) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:     if (accept && mode == MODE_LIT) state_nxt = WAIT_LIT;
        WAIT_LIT: if (accept)                     state_nxt = LIT_HI;
        LIT_HI:   if (consume)                    state_nxt = IDLE;
        default:                                  state_nxt = IDLE;
      endcase
    end
  end

  // Micro-op outputs: fields hold unless a new micro-op is loaded
  always_comb begin
    uop_valid_nxt = uop_valid;
    uop_last_nxt  = uop_last;
    srcx_nxt      = srcx;
    arga_nxt      = arga;
    argb_nxt      = argb;
    ldsinc_nxt    = ldsinc;
    lit_hi_nxt    = lit_hi;
    if (FLUSH) begin
      uop_valid_nxt = 1'b0;
      uop_last_nxt  = 1'b0;
      lit_hi_nxt    = 8'h00;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept && mode != MODE_LIT) begin
            uop_valid_nxt = 1'b1;
            uop_last_nxt  = 1'b1;
            srcx_nxt      = mode;
            arga_nxt      = bus.INSTR[7:4];
            argb_nxt      = bus.INSTR[3:0];
            ldsinc_nxt    = bus.INSTR[12:11];
          end else if (consume) begin
            uop_valid_nxt = 1'b0;
          end
        end
        WAIT_LIT: begin
          // Any accepted word is the literal, even if it looks like a prefix.
          if (accept) begin
            uop_valid_nxt = 1'b1;
            uop_last_nxt  = 1'b0;
            srcx_nxt      = SRC_U8;
            arga_nxt      = bus.INSTR[7:4];
            argb_nxt      = bus.INSTR[3:0];
            ldsinc_nxt    = 2'd0;
            lit_hi_nxt    = bus.INSTR[15:8];
          end else if (consume) begin
            uop_valid_nxt = 1'b0;
          end
        end
        LIT_HI: begin
          if (consume) begin
            uop_valid_nxt = 1'b1;
            uop_last_nxt  = 1'b1;
            srcx_nxt      = SRC_U8H;
            arga_nxt      = lit_hi[7:4];
            argb_nxt      = lit_hi[3:0];
            ldsinc_nxt    = 2'd0;
          end
        end
        default: begin
          uop_valid_nxt = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      uop_valid <= 1'b0;
      uop_last  <= 1'b0;
      srcx      <= 3'd0;
      arga      <= 4'd0;
      argb      <= 4'd0;
      ldsinc    <= 2'd0;
      lit_hi    <= 8'h00;
    end else begin
      uop_valid <= uop_valid_nxt;
      uop_last  <= uop_last_nxt;
      srcx      <= srcx_nxt;
      arga      <= arga_nxt;
      argb      <= argb_nxt;
      ldsinc    <= ldsinc_nxt;
      lit_hi    <= lit_hi_nxt;
    end
  end

  assign bus.INSTR_READY = instr_ready;
  assign bus.UOP_VALID   = uop_valid;
  assign bus.UOP_LAST    = uop_last;
  assign bus.ALUB_SRCX   = srcx;
  assign bus.ARGA_X      = arga;
  assign bus.ARGB_X      = argb;
  assign bus.LDSINCF     = ldsinc;
endmodule

// File: tb/tb_alub_uop_seq.sv
// Directed bench for alub_uop_seq: decode, LIT16 expansion, stall hold,
// back-to-back issue, flush mid-literal and async reset mid-literal.
module tb_alub_uop_seq;
  logic CLK = 1'b0;
  logic RESETN;
  logic FLUSH;
  int   errors = 0;
  int   checks = 0;

  alub_uop_seq_if u_if ();

  alub_uop_seq dut (
    .CLK    (CLK),
    .RESETN (RESETN),
    .FLUSH  (FLUSH),
    .bus    (u_if)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  // Full micro-op check: valid, srcx, A, B, ldsinc, last
  task automatic chk_uop(input string tag, input logic v, input logic [2:0] s,
                         input logic [3:0] a, input logic [3:0] b,
                         input logic [1:0] l, input logic last);
    chk({tag, ".valid"}, {15'd0, u_if.UOP_VALID}, {15'd0, v});
    chk({tag, ".srcx"},  {13'd0, u_if.ALUB_SRCX}, {13'd0, s});
    chk({tag, ".arga"},  {12'd0, u_if.ARGA_X},    {12'd0, a});
    chk({tag, ".argb"},  {12'd0, u_if.ARGB_X},    {12'd0, b});
    chk({tag, ".lds"},   {14'd0, u_if.LDSINCF},   {14'd0, l});
    chk({tag, ".last"},  {15'd0, u_if.UOP_LAST},  {15'd0, last});
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    RESETN = 1'b0;
    FLUSH  = 1'b0;
    u_if.INSTR_VALID = 1'b0;
    u_if.INSTR       = 16'h0000;
    u_if.STALL       = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk_uop("reset", 1'b0, 3'd0, 4'h0, 4'h0, 2'd0, 1'b0);
    RESETN = 1'b1;
    #1;
    chk("reset.ready", {15'd0, u_if.INSTR_READY}, 16'd1);

    // Single-word decode: 0x6A5C -> U4, ldsinc 1, A=5, B=C
    u_if.INSTR = 16'h6A5C; u_if.INSTR_VALID = 1'b1;
    tick();
    u_if.INSTR_VALID = 1'b0;
    chk_uop("dec6A5C", 1'b1, 3'd3, 4'h5, 4'hC, 2'd1, 1'b1);
    tick();
    chk("dec6A5C.drain", {15'd0, u_if.UOP_VALID}, 16'd0);
    chk("dec6A5C.hold",  {13'd0, u_if.ALUB_SRCX}, 16'd3);

    // LIT16: 0xE000 then 0xBEEF
    u_if.INSTR = 16'hE000; u_if.INSTR_VALID = 1'b1;
    tick();
    chk("lit.prefix_novalid", {15'd0, u_if.UOP_VALID}, 16'd0);
    u_if.INSTR = 16'hBEEF;
    tick();
    u_if.INSTR_VALID = 1'b0;
    chk_uop("lit.u8", 1'b1, 3'd2, 4'hE, 4'hF, 2'd0, 1'b0);
    chk("lit.u8.ready", {15'd0, u_if.INSTR_READY}, 16'd0);
    tick();
    chk_uop("lit.u8h", 1'b1, 3'd1, 4'hB, 4'hE, 2'd0, 1'b1);
    chk("lit.u8h.ready", {15'd0, u_if.INSTR_READY}, 16'd1);
    tick();
    chk("lit.drain", {15'd0, u_if.UOP_VALID}, 16'd0);

    // Stall hold: 0xA3F0 -> U6 A=F B=0 ld 0, then 3 stalled cycles with 0x0012 queued
    u_if.INSTR = 16'hA3F0; u_if.INSTR_VALID = 1'b1;
    tick();
    chk_uop("stall.a3f0", 1'b1, 3'd5, 4'hF, 4'h0, 2'd0, 1'b1);
    u_if.INSTR = 16'h0012; u_if.STALL = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall.ready", {15'd0, u_if.INSTR_READY}, 16'd0);
      tick();
      chk_uop("stall.hold", 1'b1, 3'd5, 4'hF, 4'h0, 2'd0, 1'b1);
    end
    u_if.STALL = 1'b0;
    #1;
    chk("stall.release_ready", {15'd0, u_if.INSTR_READY}, 16'd1);
    tick();
    u_if.INSTR_VALID = 1'b0;
    chk_uop("stall.0012", 1'b1, 3'd0, 4'h1, 4'h2, 2'd0, 1'b1);
    tick();
    chk("stall.drain", {15'd0, u_if.UOP_VALID}, 16'd0);

    // Back-to-back: 8 MODE-2 words, no bubbles
    u_if.INSTR_VALID = 1'b1;
    for (int i = 0; i < 8; i++) begin
      logic [3:0] a, b;
      a = 4'(i);
      b = 4'(7 - i);
      u_if.INSTR = {3'd2, 2'd0, 3'd0, a, b};
      tick();
      chk_uop("b2b", 1'b1, 3'd2, a, b, 2'd0, 1'b1);
    end
    u_if.INSTR_VALID = 1'b0;
    tick();
    chk("b2b.drain", {15'd0, u_if.UOP_VALID}, 16'd0);

    // Flush in LIT_HI after 0xE000/0x1234 U8 is issued
    u_if.INSTR = 16'hE000; u_if.INSTR_VALID = 1'b1;
    tick();
    u_if.INSTR = 16'h1234;
    tick();
    chk_uop("flush.u8", 1'b1, 3'd2, 4'h3, 4'h4, 2'd0, 1'b0);
    FLUSH = 1'b1;
    u_if.INSTR = 16'h4021;
    #1;
    chk("flush.ready", {15'd0, u_if.INSTR_READY}, 16'd0);
    tick();
    FLUSH = 1'b0;
    u_if.INSTR_VALID = 1'b0;
    chk("flush.valid", {15'd0, u_if.UOP_VALID}, 16'd0);
    chk("flush.last",  {15'd0, u_if.UOP_LAST},  16'd0);
    tick();
    chk("flush.no_u8h", {15'd0, u_if.UOP_VALID}, 16'd0);
    u_if.INSTR_VALID = 1'b1;
    tick();
    u_if.INSTR_VALID = 1'b0;
    chk_uop("flush.4021", 1'b1, 3'd2, 4'h2, 4'h1, 2'd0, 1'b1);
    tick();

    // Async reset while in WAIT_LIT with non-zero held fields
    u_if.INSTR = 16'h6A5C; u_if.INSTR_VALID = 1'b1;
    tick();
    u_if.INSTR = 16'hE000;
    tick();
    u_if.INSTR_VALID = 1'b0;
    chk("areset.pre_srcx", {13'd0, u_if.ALUB_SRCX}, 16'd3);
    #2;
    RESETN = 1'b0;
    #1;
    chk_uop("areset", 1'b0, 3'd0, 4'h0, 4'h0, 2'd0, 1'b0);
    RESETN = 1'b1;
    #1;
    chk("areset.ready", {15'd0, u_if.INSTR_READY}, 16'd1);
    u_if.INSTR = 16'hBEEF; u_if.INSTR_VALID = 1'b1;
    tick();
    u_if.INSTR_VALID = 1'b0;
    chk_uop("areset.beef", 1'b1, 3'd5, 4'hE, 4'hF, 2'd3, 1'b1);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
